// File: rtl/key_judge.sv
// Piano-tiles style judge: debounces four lane buttons, detects press edges and
// scores them against the tile sitting in the bottom row, tracking hits and lives.
module key_judge #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int START_LIVES     = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] key_n,
   input  logic       row_valid,
   input  logic [2:0] bottom_line,
   output logic [3:0] key_down,
   output logic       hit_pulse,
   output logic       miss_pulse,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic       game_over
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ARMED = 2'd1,
      S_DONE  = 2'd2,
      S_OVER  = 2'd3
   } state_e;

   function automatic logic [2:0] count_ones(input logic [3:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

   logic [3:0]          sync1_q, sync1_d;
   logic [3:0]          sync2_q, sync2_d;
   logic [3:0][CW-1:0]  cnt_q, cnt_d;
   logic [3:0]          key_down_q, key_down_d;
   logic [3:0]          key_down_dly_q, key_down_dly_d;
   logic [3:0]          press_q, press_d;

   state_e              state_q, state_d;
   logic [1:0]          lane_q, lane_d;
   logic [7:0]          score_q, score_d;
   logic [1:0]          lives_q, lives_d;
   logic                hit_q, hit_d;
   logic                miss_q, miss_d;
   logic                game_over_q, game_over_d;

   logic [2:0]          n_press_s;
   logic                any_press_s;
   logic                single_press_s;
   logic [3:0]          lane_onehot_s;
   logic                hit_ev_s;
   logic                miss_ev_s;

   // Synchronizers hold the pressed (inverted) level so a cleared flop means released.
   always_comb begin
      sync1_d        = ~key_n;
      sync2_d        = sync1_q;
      cnt_d          = cnt_q;
      key_down_d     = key_down_q;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] == key_down_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]      = '0;
            key_down_d[i] = sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
      key_down_dly_d = key_down_q;
      press_d        = key_down_q & ~key_down_dly_q;
   end

   always_comb begin
      n_press_s      = count_ones(press_q);
      any_press_s    = (n_press_s != 3'd0);
      single_press_s = (n_press_s == 3'd1);
      lane_onehot_s  = 4'b0001 << lane_q;
      hit_ev_s       = 1'b0;
      miss_ev_s      = 1'b0;
      case (state_q)
         S_ARMED: begin
            // A press coincident with a new row is judged against the outgoing tile only.
            if (single_press_s && ((press_q & lane_onehot_s) != 4'b0000)) begin
               hit_ev_s = 1'b1;
            end else if (any_press_s) begin
               miss_ev_s = 1'b1;
            end else if (row_valid) begin
               miss_ev_s = 1'b1;
            end else begin
               miss_ev_s = 1'b0;
            end
         end
         S_EMPTY, S_DONE: begin
            miss_ev_s = any_press_s;
         end
         S_OVER: begin
            hit_ev_s  = 1'b0;
            miss_ev_s = 1'b0;
         end
         default: begin
            hit_ev_s  = 1'b0;
            miss_ev_s = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      case (state_q)
         S_OVER: begin
            state_d = S_OVER;
         end
         S_EMPTY, S_ARMED, S_DONE: begin
            if (miss_ev_s && (lives_q == 2'd1)) begin
               state_d = S_OVER;
            end else if (row_valid) begin
               if (bottom_line[2]) begin
                  state_d = S_ARMED;
                  lane_d  = bottom_line[1:0];
               end else begin
                  state_d = S_EMPTY;
               end
            end else if ((state_q == S_ARMED) && any_press_s) begin
               state_d = S_DONE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase
   end

   always_comb begin
      hit_d  = hit_ev_s;
      miss_d = miss_ev_s;
      if (hit_ev_s && (score_q != 8'hFF)) begin
         score_d = score_q + 8'd1;
      end else begin
         score_d = score_q;
      end
      if (miss_ev_s && (lives_q != 2'd0)) begin
         lives_d = lives_q - 2'd1;
      end else begin
         lives_d = lives_q;
      end
      game_over_d = (state_d == S_OVER);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q        <= 4'b0000;
         sync2_q        <= 4'b0000;
         cnt_q          <= '0;
         key_down_q     <= 4'b0000;
         key_down_dly_q <= 4'b0000;
         press_q        <= 4'b0000;
         state_q        <= S_EMPTY;
         lane_q         <= 2'd0;
         score_q        <= 8'd0;
         lives_q        <= LIVES_INIT;
         hit_q          <= 1'b0;
         miss_q         <= 1'b0;
         game_over_q    <= 1'b0;
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         cnt_q          <= cnt_d;
         key_down_q     <= key_down_d;
         key_down_dly_q <= key_down_dly_d;
         press_q        <= press_d;
         state_q        <= state_d;
         lane_q         <= lane_d;
         score_q        <= score_d;
         lives_q        <= lives_d;
         hit_q          <= hit_d;
         miss_q         <= miss_d;
         game_over_q    <= game_over_d;
      end
   end

   assign key_down   = key_down_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;
   assign score      = score_q;
   assign lives      = lives_q;
   assign game_over  = game_over_q;

endmodule

// File: tb/tb_key_judge.sv
// Directed bench for key_judge with DEBOUNCE_CYCLES=4, START_LIVES=3.
module tb_key_judge;

   logic       clock;
   logic       reset;
   logic [3:0] key_n;
   logic       row_valid;
   logic [2:0] bottom_line;
   logic [3:0] key_down;
   logic       hit_pulse;
   logic       miss_pulse;
   logic [7:0] score;
   logic [1:0] lives;
   logic       game_over;

   int n_checks = 0;
   int n_fail   = 0;
   int hit_seen = 0;
   int miss_seen = 0;
   int both_seen = 0;
   logic [3:0] last_kd;
   logic [3:0] kd_any;

   key_judge #(.DEBOUNCE_CYCLES(4), .START_LIVES(3)) dut (
      .clock(clock), .reset(reset), .key_n(key_n), .row_valid(row_valid),
      .bottom_line(bottom_line), .key_down(key_down), .hit_pulse(hit_pulse),
      .miss_pulse(miss_pulse), .score(score), .lives(lives), .game_over(game_over)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      if (hit_pulse) hit_seen++;
      if (miss_pulse) miss_seen++;
      if (hit_pulse && miss_pulse) both_seen++;
   end

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; key_n = 4'hF; row_valid = 1'b0; bottom_line = 3'b000;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      hit_seen = 0; miss_seen = 0;
   endtask

   task automatic send_row(input logic [2:0] code);
      @(negedge clock);
      row_valid = 1'b1; bottom_line = code;
      @(negedge clock);
      row_valid = 1'b0; bottom_line = 3'b000;
   endtask

   task automatic press_keys(input logic [3:0] mask, input int bounces);
      @(negedge clock);
      for (int i = 0; i < bounces; i++) begin
         key_n = (i % 2 == 0) ? ~mask : 4'hF;
         @(negedge clock);
      end
      key_n = ~mask;
      repeat (14) @(negedge clock);
      last_kd = key_down;
      key_n = 4'hF;
      repeat (12) @(negedge clock);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (score !== 8'd0) begin $display("FAIL reset_score: got %0d want 0", score); n_fail++; end
      n_checks++; if (lives !== 2'd3) begin $display("FAIL reset_lives: got %0d want 3", lives); n_fail++; end
      n_checks++; if (game_over !== 1'b0) begin $display("FAIL reset_game_over: got %0b want 0", game_over); n_fail++; end
      n_checks++; if ({hit_pulse, miss_pulse} !== 2'b00) begin $display("FAIL reset_pulses: got %b want 00", {hit_pulse, miss_pulse}); n_fail++; end
      n_checks++; if (key_down !== 4'b0000) begin $display("FAIL reset_key_down: got %b want 0000", key_down); n_fail++; end
   endtask

   task automatic test_latency();
      do_reset();
      send_row(3'b100);
      @(negedge clock);
      key_n = 4'b1110;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clock);
         if (c == 5) begin
            n_checks++; if (key_down !== 4'b0000) begin $display("FAIL lat_kd_early: got %b want 0000", key_down); n_fail++; end
         end
         if (c == 6) begin
            n_checks++; if (key_down !== 4'b0001) begin $display("FAIL lat_kd_on: got %b want 0001", key_down); n_fail++; end
         end
         if (c == 7) begin
            n_checks++; if (hit_pulse !== 1'b0) begin $display("FAIL lat_hit_early: got %b want 0", hit_pulse); n_fail++; end
         end
         if (c == 8) begin
            n_checks++; if (hit_pulse !== 1'b1) begin $display("FAIL lat_hit_on: got %b want 1", hit_pulse); n_fail++; end
         end
         if (c == 9) begin
            n_checks++; if (hit_pulse !== 1'b0) begin $display("FAIL lat_hit_width: got %b want 0", hit_pulse); n_fail++; end
         end
      end
      key_n = 4'hF;
      repeat (12) @(negedge clock);
      n_checks++; if (score !== 8'd1) begin $display("FAIL lat_score: got %0d want 1", score); n_fail++; end
      n_checks++; if (hit_seen !== 1 || miss_seen !== 0) begin $display("FAIL lat_release_events: got hits=%0d misses=%0d want 1/0", hit_seen, miss_seen); n_fail++; end
   endtask

   task automatic test_glitch();
      do_reset();
      kd_any = 4'b0000;
      @(negedge clock);
      key_n = 4'b1101;
      repeat (3) begin @(negedge clock); kd_any = kd_any | key_down; end
      key_n = 4'hF;
      repeat (12) begin @(negedge clock); kd_any = kd_any | key_down; end
      n_checks++; if (kd_any !== 4'b0000) begin $display("FAIL glitch_key_down: got %b want 0000", kd_any); n_fail++; end
      n_checks++; if (miss_seen !== 0 || lives !== 2'd3) begin $display("FAIL glitch_events: got misses=%0d lives=%0d want 0/3", miss_seen, lives); n_fail++; end
   endtask

   task automatic test_bounce_hit();
      do_reset();
      send_row(3'b110);
      press_keys(4'b0100, 4);
      n_checks++; if (hit_seen !== 1) begin $display("FAIL bounce_hits: got %0d want 1", hit_seen); n_fail++; end
      n_checks++; if (score !== 8'd1 || lives !== 2'd3) begin $display("FAIL bounce_score_lives: got %0d/%0d want 1/3", score, lives); n_fail++; end
   endtask

   task automatic test_wrong_lane();
      do_reset();
      send_row(3'b101);
      press_keys(4'b1000, 0);
      n_checks++; if (miss_seen !== 1 || lives !== 2'd2) begin $display("FAIL wrong_lane_miss: got misses=%0d lives=%0d want 1/2", miss_seen, lives); n_fail++; end
      press_keys(4'b0010, 0);
      n_checks++; if (miss_seen !== 2 || lives !== 2'd1) begin $display("FAIL done_press_miss: got misses=%0d lives=%0d want 2/1", miss_seen, lives); n_fail++; end
      n_checks++; if (hit_seen !== 0 || game_over !== 1'b0) begin $display("FAIL wrong_lane_state: got hits=%0d over=%0b want 0/0", hit_seen, game_over); n_fail++; end
   endtask

   task automatic test_unhit_row();
      do_reset();
      send_row(3'b100);
      repeat (3) @(negedge clock);
      row_valid = 1'b1; bottom_line = 3'b000;
      @(negedge clock);
      row_valid = 1'b0;
      n_checks++; if (miss_pulse !== 1'b1) begin $display("FAIL unhit_miss_pulse: got %b want 1", miss_pulse); n_fail++; end
      @(negedge clock);
      n_checks++; if (miss_pulse !== 1'b0 || lives !== 2'd2 || miss_seen !== 1) begin $display("FAIL unhit_once: got pulse=%b lives=%0d misses=%0d want 0/2/1", miss_pulse, lives, miss_seen); n_fail++; end
      press_keys(4'b0001, 0);
      n_checks++; if (miss_seen !== 2 || hit_seen !== 0 || lives !== 2'd1) begin $display("FAIL empty_press: got misses=%0d hits=%0d lives=%0d want 2/0/1", miss_seen, hit_seen, lives); n_fail++; end
   endtask

   task automatic test_coincident();
      do_reset();
      send_row(3'b100);
      @(negedge clock);
      key_n = 4'b1110;
      repeat (7) @(negedge clock);
      row_valid = 1'b1; bottom_line = 3'b111;
      @(negedge clock);
      row_valid = 1'b0; bottom_line = 3'b000;
      n_checks++; if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0) begin $display("FAIL coinc_pulse: got hit=%b miss=%b want 1/0", hit_pulse, miss_pulse); n_fail++; end
      repeat (6) @(negedge clock);
      key_n = 4'hF;
      repeat (12) @(negedge clock);
      n_checks++; if (score !== 8'd1 || lives !== 2'd3 || miss_seen !== 0) begin $display("FAIL coinc_totals: got score=%0d lives=%0d misses=%0d want 1/3/0", score, lives, miss_seen); n_fail++; end
      press_keys(4'b1000, 0);
      n_checks++; if (score !== 8'd2 || hit_seen !== 2) begin $display("FAIL coinc_armed_lane3: got score=%0d hits=%0d want 2/2", score, hit_seen); n_fail++; end
   endtask

   task automatic test_game_over();
      do_reset();
      press_keys(4'b0001, 0);
      press_keys(4'b0010, 0);
      press_keys(4'b0100, 0);
      n_checks++; if (lives !== 2'd0 || game_over !== 1'b1 || miss_seen !== 3) begin $display("FAIL over_entry: got lives=%0d over=%b misses=%0d want 0/1/3", lives, game_over, miss_seen); n_fail++; end
      hit_seen = 0; miss_seen = 0;
      send_row(3'b100);
      press_keys(4'b0001, 0);
      n_checks++; if (hit_seen !== 0 || miss_seen !== 0 || score !== 8'd0 || lives !== 2'd0) begin $display("FAIL over_ignore: got hits=%0d misses=%0d score=%0d lives=%0d want 0/0/0/0", hit_seen, miss_seen, score, lives); n_fail++; end
      n_checks++; if (last_kd !== 4'b0001) begin $display("FAIL over_key_track: got %b want 0001", last_kd); n_fail++; end
      do_reset();
      n_checks++; if (score !== 8'd0 || lives !== 2'd3 || game_over !== 1'b0) begin $display("FAIL over_reset: got score=%0d lives=%0d over=%b want 0/3/0", score, lives, game_over); n_fail++; end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 255; i++) begin
         send_row(3'b100);
         press_keys(4'b0001, 0);
      end
      n_checks++; if (score !== 8'd255 || hit_seen !== 255) begin $display("FAIL sat_reach: got score=%0d hits=%0d want 255/255", score, hit_seen); n_fail++; end
      hit_seen = 0;
      send_row(3'b101);
      press_keys(4'b0010, 0);
      n_checks++; if (score !== 8'd255 || hit_seen !== 1) begin $display("FAIL sat_hold: got score=%0d hits=%0d want 255/1", score, hit_seen); n_fail++; end
      hit_seen = 0; miss_seen = 0;
      send_row(3'b100);
      press_keys(4'b0011, 0);
      n_checks++; if (miss_seen !== 1 || hit_seen !== 0 || lives !== 2'd2 || score !== 8'd255) begin $display("FAIL multi_press: got misses=%0d hits=%0d lives=%0d score=%0d want 1/0/2/255", miss_seen, hit_seen, lives, score); n_fail++; end
   endtask

   task automatic test_reset_hold();
      do_reset();
      send_row(3'b100);
      @(negedge clock);
      key_n = 4'b1110;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      hit_seen = 0; miss_seen = 0;
      n_checks++; if (key_down !== 4'b0000) begin $display("FAIL hold_kd_cleared: got %b want 0000", key_down); n_fail++; end
      repeat (12) @(negedge clock);
      n_checks++; if (key_down !== 4'b0001 || miss_seen !== 1 || hit_seen !== 0 || lives !== 2'd2) begin $display("FAIL hold_one_edge: got kd=%b misses=%0d hits=%0d lives=%0d want 0001/1/0/2", key_down, miss_seen, hit_seen, lives); n_fail++; end
      key_n = 4'hF;
      repeat (12) @(negedge clock);
   endtask

   initial begin
      reset = 1'b1; key_n = 4'hF; row_valid = 1'b0; bottom_line = 3'b000;
      last_kd = 4'b0000; kd_any = 4'b0000;
      test_reset();
      test_latency();
      test_glitch();
      test_bounce_hit();
      test_wrong_lane();
      test_unhit_row();
      test_coincident();
      test_game_over();
      test_saturation();
      test_reset_hold();
      n_checks++; if (both_seen !== 0) begin $display("FAIL hit_miss_exclusive: got %0d overlaps want 0", both_seen); n_fail++; end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_judge.md
KEY_JUDGE -- requirements
Module: key_judge

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, sets consecutive stable samples (10 ms at 50 MHz) before a key level is accepted.
REQ-002 Parameter START_LIVES, default 3, sets lives loaded at reset; legal range 1..3.
REQ-003 clock  input  1  system clock (CLOCK_50 domain).
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 key_n  input  4  raw lane pushbuttons, active-low, asynchronous and bouncing; bit i = lane i.
REQ-006 row_valid  input  1  one-cycle pulse: a new row has shifted into the bottom (judge) position.
REQ-007 bottom_line  input  3  bottom row code, sampled on row_valid: bit2 = tile present, bits[1:0] = tile lane.
REQ-008 key_down  output  4  debounced key levels, 1 = pressed.
REQ-009 hit_pulse  output  1  one-cycle pulse on a correct press.
REQ-010 miss_pulse  output  1  one-cycle pulse on any miss event.
REQ-011 score  output  8  count of hits, saturating.
REQ-012 lives  output  2  remaining lives.
REQ-013 game_over  output  1  high while in OVER state.

Function
REQ-014 Each key_n bit SHALL pass a two-flop synchronizer, then a per-lane counter; key_down[i] SHALL change only after DEBOUNCE_CYCLES consecutive synchronized samples differing from the current key_down[i].
REQ-015 Any sample equal to current key_down[i] SHALL clear lane i counter.
REQ-016 A press edge on lane i SHALL be a registered 0->1 transition of key_down[i], asserted for exactly one cycle; releases SHALL generate no event.
REQ-017 Press-to-edge latency from a clean key_n fall SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-018 FSM states: EMPTY (no judgeable tile), ARMED (tile present, unjudged), DONE (current tile judged), OVER.
REQ-019 In EMPTY/DONE, row_valid with bottom_line[2]=1 SHALL latch lane = bottom_line[1:0] and go ARMED; with bottom_line[2]=0 SHALL go EMPTY.
REQ-020 In ARMED, row_valid with no same-cycle press edge SHALL count one miss (tile left unhit), then apply REQ-019 to the new row.
REQ-021 In ARMED, a single press edge on the latched lane SHALL assert hit_pulse next cycle, increment score, go DONE.
REQ-022 In ARMED, a single press edge on another lane SHALL count one miss and go DONE.
REQ-023 Press edges on two or more lanes in the same cycle SHALL count one miss (in ARMED go DONE; in EMPTY/DONE stay).
REQ-024 A single press edge in EMPTY or DONE SHALL count one miss.
REQ-025 Press edge and row_valid in the same cycle: press SHALL be judged against the outgoing row first; the outgoing row SHALL NOT also count as an unhit miss; the new row then applies REQ-019.
REQ-026 At most one miss SHALL be counted per cycle; each miss asserts miss_pulse one cycle and decrements lives by 1.
REQ-027 A miss taking lives from 1 to 0 SHALL enter OVER; game_over=1 from the following cycle.
REQ-028 OVER SHALL ignore row_valid and press edges; hit_pulse=miss_pulse=0; score and lives hold; key_down still tracks keys; exit only via reset.
REQ-029 score SHALL saturate at 255; a hit at 255 still pulses hit_pulse.
REQ-030 hit_pulse and miss_pulse SHALL never be high in the same cycle.

Reset
REQ-031 reset high at a clock edge SHALL, next cycle: state EMPTY, score=0, lives=START_LIVES, game_over=0, hit_pulse=miss_pulse=0, key_down=0, debounce counters and synchronizers cleared.
REQ-032 Reset mid-debounce or mid-ARMED SHALL discard pending events; a key held through reset SHALL produce one press edge after full debounce following release of reset.

Verification (DEBOUNCE_CYCLES=4, START_LIVES=3)
REQ-033 row_valid with bottom_line=3'b110, key_n[2] low 20 cycles with 3 bounces in first 3 cycles -> one hit_pulse, score=1, lives=3.
REQ-034 row_valid 3'b101, press lane 3 -> miss_pulse, lives=2; further lane-1 press before next row -> second miss, lives=1.
REQ-035 row_valid 3'b100, no press, row_valid 3'b000 -> one miss at second row_valid, state EMPTY.
REQ-036 Press edge lane 0 coincident with row_valid 3'b111 while ARMED on lane 0 -> hit, no miss, state ARMED lane 3.
REQ-037 Three misses -> lives=0, game_over=1; subsequent correct presses -> no pulses, score unchanged; reset -> score=0, lives=3, game_over=0.
REQ-038 255 hits then one more -> score holds 255, hit_pulse still asserted; keys 0 and 1 pressed same cycle while ARMED -> exactly one miss.
